// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, controller states, lane count.
package mem_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: misalignment/illegal-size check, store strobe and lane
// replication, and load extraction with sign or zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       off,
  input  logic             is_unsigned,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic             misaligned,
  output logic [LANES-1:0] wstrb,
  output logic [31:0]      wdata_lane,
  output logic [31:0]      rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  // Alignment check, strobe/lane generation and load extension by size.
  always_comb begin
    misaligned = 1'b0;
    wstrb      = '0;
    wdata_lane = '0;
    rdata_ext  = shifted;
    case (size)
      SZ_B: begin
        wstrb      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        misaligned = off[0];
        wstrb      = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        misaligned = (off != 2'b00);
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = shifted;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit bridging the EX stage to a request/acknowledge data RAM of
// unbounded latency, with pipeline stall, wait timeout and error reporting.
//
// state  | meaning
// IDLE   | ready; accepts a request, checks alignment
// ACCESS | mem_req held with stable address/data; waits for mem_ack or timeout
// RESP   | one-cycle resp_valid pulse with data/error
module lsu_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [LANES-1:0]  mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LANES-1:0]  wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              is_idle;
  logic              timeout_hit;
  logic [1:0]        al_size;
  logic [1:0]        al_off;
  logic              al_uns;
  logic              al_misaligned;
  logic [LANES-1:0]  al_wstrb;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              unused_addr_hi;

  assign is_idle        = (state == IDLE);
  assign timeout_hit    = (cnt == CNT_LAST);
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // In IDLE the aligner looks at the incoming request; afterwards it works on
  // the latched request so load extraction uses the accepted size/offset.
  assign al_size = is_idle ? req_size     : size_q;
  assign al_off  = is_idle ? req_addr[1:0] : off_q;
  assign al_uns  = is_idle ? req_unsigned : uns_q;

  lsu_align u_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (al_uns),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .misaligned  (al_misaligned),
    .wstrb       (al_wstrb),
    .wdata_lane  (al_wdata),
    .rdata_ext   (al_rdata)
  );

  // Next-state decode; ack takes priority over the timeout in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (req_valid) state_n = al_misaligned ? RESP : ACCESS;
      ACCESS: if (mem_ack || timeout_hit) state_n = RESP;
      RESP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, wait counter and latched request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            addr_q  <= req_addr[ADDR_W+1:2];
            wstrb_q <= req_we ? al_wstrb : '0;
            wdata_q <= req_we ? al_wdata : '0;
            rdata_q <= '0;
            err_q   <= al_misaligned;
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_ack) begin
            rdata_q <= we_q ? 32'h0 : al_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign req_ready  = is_idle;
  assign stall      = !is_idle;
  assign mem_req    = (state == ACCESS);
  assign mem_we     = mem_req & we_q;
  assign mem_wstrb  = mem_we ? wstrb_q : '0;
  assign mem_wdata  = mem_we ? wdata_q : '0;
  assign mem_addr   = mem_req ? addr_q : '0;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with TIMEOUT=8: table of single accesses
// plus hand-written timeout, late-ack, stray-ack and async-reset sequences.
module tb_lsu_mem_ctrl;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [15:0] e_addr;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    check({p, " ready"}, 32'(req_ready), 32'd1);
    drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
    step();
    req_valid = 1'b0;
    if (v.e_err) begin
      check({p, " err_valid"}, 32'(resp_valid), 32'd1);
      check({p, " err_flag"}, 32'(resp_err), 32'd1);
      check({p, " err_rdata"}, resp_rdata, 32'h0);
      check({p, " err_mem_req"}, 32'(mem_req), 32'd0);
      check({p, " err_stall"}, 32'(stall), 32'd1);
    end else begin
      for (int i = 0; i <= v.waits; i++) begin
        check({p, $sformatf(" mem_req c%0d", i)}, 32'(mem_req), 32'd1);
        check({p, $sformatf(" mem_addr c%0d", i)}, 32'(mem_addr), 32'(v.e_addr));
        check({p, $sformatf(" mem_we c%0d", i)}, 32'(mem_we), 32'(v.we));
        check({p, $sformatf(" wstrb c%0d", i)}, 32'(mem_wstrb), 32'(v.e_wstrb));
        check({p, $sformatf(" wdata c%0d", i)}, mem_wdata, v.e_wdata);
        check({p, $sformatf(" early_valid c%0d", i)}, 32'(resp_valid), 32'd0);
        if (i == v.waits) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
      check({p, " resp_valid"}, 32'(resp_valid), 32'd1);
      check({p, " resp_err"}, 32'(resp_err), 32'd0);
      check({p, " resp_rdata"}, resp_rdata, v.e_rdata);
      check({p, " resp_mem_req"}, 32'(mem_req), 32'd0);
    end
    step();
    check({p, " idle_ready"}, 32'(req_ready), 32'd1);
    check({p, " idle_stall"}, 32'(stall), 32'd0);
    check({p, " pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          we    size   uns   addr          wdata         rdata         w  err   e_rdata       wstrb    e_wdata       e_addr
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0,        16'h0040};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,        16'h0040};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 3, 1'b0, 32'h0,        4'b1100, 32'hABCD_ABCD, 16'h0080};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        16'h0000};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        16'h0000};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0,        16'h0000};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 1'b0, 32'h0000_8001, 4'b0000, 32'h0,        16'h0000};
    vecs[7]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0004, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0,        16'h0001};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 1, 1'b0, 32'h0,        4'b0010, 32'hA5A5_A5A5, 16'h0000};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1234_5678, 32'h0,        0, 1'b0, 32'h0,        4'b1111, 32'h1234_5678, 16'h0002};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_1111, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        16'h0000};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_7F00, 0, 1'b0, 32'h0000_007F, 4'b0000, 32'h0,        16'h0004};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,        32'hFFFF_FF01, 0, 1'b0, 32'h0000_0001, 4'b0000, 32'h0,        16'h0004};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'h0;
    #12;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst stall", 32'(stall), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Timeout: no ack, mem_req must stay up for exactly TIMEOUT cycles.
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
    step();
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      n++;
      step();
    end
    check("to req_cycles", 32'(n), 32'(TIMEOUT));
    check("to resp_valid", 32'(resp_valid), 32'd1);
    check("to resp_err", 32'(resp_err), 32'd1);
    check("to resp_rdata", resp_rdata, 32'h0);
    step();
    check("to ready", 32'(req_ready), 32'd1);

    // Ack in the last allowed ACCESS cycle wins over the timeout.
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("late still_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check("late resp_valid", 32'(resp_valid), 32'd1);
    check("late resp_err", 32'(resp_err), 32'd0);
    check("late resp_rdata", resp_rdata, 32'hCAFE_F00D);
    step();

    // Stray ack while idle does nothing.
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    step();
    check("stray resp_valid", 32'(resp_valid), 32'd0);
    check("stray mem_req", 32'(mem_req), 32'd0);
    check("stray stall", 32'(stall), 32'd0);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Async reset in the middle of an access.
    drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0BAD_0BAD);
    step();
    req_valid = 1'b0;
    step();
    check("ar pre mem_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar mem_req", 32'(mem_req), 32'd0);
    check("ar stall", 32'(stall), 32'd0);
    check("ar resp_valid", 32'(resp_valid), 32'd0);
    check("ar ready", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("ar after_release mem_req", 32'(mem_req), 32'd0);
    run_vec(100, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised load/store unit for the multi-cycle and pipelined successors of the single-cycle core.
- Replaces the fixed one-cycle DRAM path with a request/acknowledge memory interface of unbounded latency.
- Provides a pipeline stall, byte-lane write strobes, load sign/zero extension, misalignment detection and a wait timeout.
- Sits between the EX stage (address from the ALU, store data from rs2) and the data RAM.

Parameters:
- ADDR_W, 16, width of the word address driven to the DRAM (byte address bits [ADDR_W+1:2]).
- TIMEOUT, 255, maximum ACCESS cycles without mem_ack before the access aborts with an error (≥2).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W ≥ TIMEOUT.

Ports:
- clk, in, 1, core clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, EX presents a memory operation.
- req_ready, out, 1, unit can accept a request this cycle.
- req_we, in, 1, 1 = store, 0 = load.
- req_size, in, 2, 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned, in, 1, zero-extend the load (lbu/lhu).
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, right-aligned.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, 32, extended load data; 0 for stores and errors.
- resp_err, out, 1, misaligned, illegal size or timeout; valid with resp_valid.
- stall, out, 1, hold the upstream pipeline.
- mem_req, out, 1, DRAM request.
- mem_we, out, 1, DRAM write.
- mem_wstrb, out, 4, byte-lane enables.
- mem_addr, out, ADDR_W, word address.
- mem_wdata, out, 32, lane-replicated store data.
- mem_ack, in, 1, DRAM completion.
- mem_rdata, in, 32, DRAM read word, valid with mem_ack.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, counter 0, req_ready 1, all other outputs 0. A reset mid-access drops mem_req immediately and discards the request.
- req_ready = (state == IDLE). stall = (state != IDLE). Both are decoded from registered state.
- IDLE:
  - Accept when req_valid is high. Latch we, size, unsigned, addr[1:0], word address, lane data and strobes.
  - Illegal size, half with addr[0]=1, or word with addr[1:0]≠0 → RESP with err=1. mem_req is never raised.
  - Otherwise → ACCESS.
  - req_valid outside IDLE is ignored, not queued; the requester holds it.
- ACCESS:
  - mem_req=1. mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until exit.
  - Counter increments each cycle.
  - mem_ack → capture the extended mem_rdata (loads) and go to RESP with err=0.
  - Counter == TIMEOUT-1 without ack → RESP with err=1.
  - mem_ack coincident with the timeout cycle: ack wins.
  - mem_req deasserts in the cycle after ack or timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The counter clears on entry to IDLE.
- mem_ack in IDLE or RESP is ignored.
- Latency:
  - Accept at cycle 0, mem_req at cycle 1.
  - Zero-wait ack at cycle 1 → resp_valid at cycle 2.
  - Error detected at accept → resp_valid at cycle 1.
  - Back-to-back requests: next accept in the cycle after resp_valid.
- Store lanes, with off = addr[1:0]:
  - Byte: wstrb = 0001<<off, wdata = {4{b}}.
  - Half: wstrb = 0011<<off, wdata = {2{h}}.
  - Word: wstrb = 1111.
- Loads: mem_we=0, wstrb=0000.
- Load extract: shift mem_rdata right by off*8. Byte and half are sign-extended unless req_unsigned. For words, req_unsigned is ignored.

Decomposition:
- Package mem_pkg: size encodings (SZ_B, SZ_H, SZ_W), state encoding (IDLE, ACCESS, RESP), lane count 4.
- One combinational sub-module lsu_align: misalignment check, wstrb/wdata generation and load extraction/extension. Reused by later cache work.

Test Plan:
1. Load byte, signed, addr 0x103, mem_rdata 0x80FF1234, ack at cycle 1 → mem_addr 0x040, resp_valid at cycle 2, resp_rdata 0xFFFFFF80, err 0. The same load with req_unsigned=1 → 0x00000080.
2. Store half, data 0x0000ABCD to 0x202, ack after 3 waits → mem_we 1, wstrb 1100, wdata 0xABCDABCD stable for 4 cycles, then resp_valid with resp_rdata 0.
3. Load word at 0x101, and separately size 11 → mem_req stays 0, resp_valid and resp_err at cycle 1, stall high for 1 cycle.
4. TIMEOUT=8, no ack → mem_req high for 8 cycles, then resp_err 1, unit returns to IDLE with req_ready 1.
5. TIMEOUT=8, ack in the 8th ACCESS cycle → resp_err 0, data returned. A stray ack in IDLE has no effect.
6. rst_n low during ACCESS → mem_req, stall and resp_valid go to 0 asynchronously, req_ready 1. A new request after release completes normally.
